// File: rtl/fsm_cmd_arbiter.sv
// Round-robin session arbiter in front of the protected sequence FSM's a/b/c/d command port.
// Failed sessions are counted per requester, and a requester is locked out after LOCK_THRESH failures.
module fsm_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LOCK_THRESH = 3,
  parameter int TIMEOUT     = 16,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int FW = $clog2(LOCK_THRESH + 1),
  localparam int CW = $clog2(TIMEOUT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [4*NUM_REQ-1:0] req_cmd,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 a,
  output logic                 b,
  output logic                 c,
  output logic                 d,
  input  logic                 finished,
  output logic                 busy,
  output logic [OW-1:0]        owner,
  output logic [NUM_REQ-1:0]   locked,
  output logic                 done_pulse,
  output logic                 fail_pulse,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_WAIT} state_t;

  state_t           state;
  logic [OW-1:0]    ptr;
  logic [CW-1:0]    cnt;
  logic [FW-1:0]    fail_cnt [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               pick_valid;
  logic [OW-1:0]      pick_idx;
  logic [3:0]         cur_cmd;
  logic               cmd_legal;
  logic               sess_ok;
  logic               sess_fail;
  logic [OW-1:0]      ptr_next;

  assign eligible  = req & ~locked;
  assign cur_cmd   = req_cmd[4*int'(owner) +: 4];
  assign cmd_legal = (cur_cmd & (cur_cmd - 4'd1)) == 4'd0;
  assign ptr_next  = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + OW'(1);
  assign busy      = (state != ST_IDLE);
  assign state_dbg = state;

  // First eligible requester at or after the pointer, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_valid && eligible[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = OW'(idx);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (state == ST_DRIVE) gnt[owner] = 1'b1;
  end

  // A WAIT cycle that sees finished succeeds even when it is also the timeout cycle.
  always_comb begin
    sess_ok   = 1'b0;
    sess_fail = 1'b0;
    case (state)
      ST_DRIVE: begin
        if (req[owner]) sess_fail = !cmd_legal;
        else            sess_fail = (cnt == CW'(TIMEOUT - 1));
      end
      ST_WAIT: begin
        sess_ok   = finished;
        sess_fail = !finished && (cnt == CW'(TIMEOUT - 1));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      owner      <= '0;
      ptr        <= '0;
      cnt        <= '0;
      {d, c, b, a} <= 4'b0000;
      done_pulse <= 1'b0;
      fail_pulse <= 1'b0;
      locked     <= '0;
      for (int i = 0; i < NUM_REQ; i++) fail_cnt[i] <= '0;
    end else begin
      {d, c, b, a} <= 4'b0000;
      done_pulse   <= 1'b0;
      fail_pulse   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            cnt   <= '0;
            state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (req[owner]) begin
            if (cmd_legal) begin
              {d, c, b, a} <= cur_cmd;
              cnt          <= '0;
              if (req_last[owner]) state <= ST_WAIT;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CW'(1);
        end
        default: state <= ST_IDLE;
      endcase

      // Session end overrides the per-state updates above.
      if (sess_ok || sess_fail) begin
        state <= ST_IDLE;
        ptr   <= ptr_next;
        cnt   <= '0;
      end
      if (sess_ok) begin
        done_pulse      <= 1'b1;
        fail_cnt[owner] <= '0;
      end
      if (sess_fail) begin
        fail_pulse <= 1'b1;
        if (fail_cnt[owner] != FW'(LOCK_THRESH))
          fail_cnt[owner] <= fail_cnt[owner] + FW'(1);
        if (fail_cnt[owner] >= FW'(LOCK_THRESH - 1))
          locked[owner] <= 1'b1;
      end
    end
  end

endmodule
